bm2p_rd_sched: RTL and testbench

BM2P_RD_SCHED -- requirements
Module: bm2p_rd_sched

---
 rtl/bm2p_pkg.sv | 19 +
 rtl/bm2p_rr_arb.sv | 30 +++
 rtl/bm2p_rd_sched.sv | 103 ++++++++++
 tb/tb_bm2p_rd_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bm2p_pkg.sv
// Shared types and helpers for the block-memory read-port scheduler.
package bm2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int unsigned ADDR_FN_W = 32;

  // Next word address, wrapping to 0 after last_addr (depth need not be a power of 2).
  function automatic logic [ADDR_FN_W-1:0] addr_wrap_inc(
    input logic [ADDR_FN_W-1:0] addr,
    input logic [ADDR_FN_W-1:0] last_addr
  );
    return (addr == last_addr) ? '0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/bm2p_rr_arb.sv
// Round-robin requester selection; search starts one past the last grant.
module bm2p_rr_arb #(
  parameter  int unsigned G_NREQ = 4,
  localparam int unsigned IDXW   = (G_NREQ > 1) ? $clog2(G_NREQ) : 1
) (
  input  logic [G_NREQ-1:0] req,
  input  logic [IDXW-1:0]   last,
  output logic [G_NREQ-1:0] gnt,
  output logic [IDXW-1:0]   idx
);

  always_comb begin
    int unsigned cand;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= G_NREQ; i++) begin
      cand = 32'(last) + i;
      if (cand >= G_NREQ) cand = cand - G_NREQ;
      if (!found && req[IDXW'(cand)]) begin
        found               = 1'b1;
        gnt[IDXW'(cand)]    = 1'b1;
        idx                 = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/bm2p_rd_sched.sv
// Schedules burst reads from several requesters onto one block-memory read port.
module bm2p_rd_sched
  import bm2p_pkg::*;
#(
  parameter  int unsigned G_MEMWIDTH  = 32,
  parameter  int unsigned G_MEMDEPTH  = 1024,
  parameter  int unsigned G_NREQ      = 4,
  parameter  int unsigned G_LENWIDTH  = 8,
  localparam int unsigned G_ADDRWIDTH = $clog2(G_MEMDEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [G_NREQ-1:0]              rd_req,
  input  logic [G_NREQ*G_ADDRWIDTH-1:0]  rd_addr,
  input  logic [G_NREQ*G_LENWIDTH-1:0]   rd_len,
  output logic [G_NREQ-1:0]              rd_gnt,
  output logic [G_NREQ-1:0]              rd_rvalid,
  output logic [G_NREQ-1:0]              rd_rlast,
  output logic [G_MEMWIDTH-1:0]          rd_rdata,
  output logic                           mem_enb,
  output logic [G_ADDRWIDTH-1:0]         mem_addrb,
  input  logic [G_MEMWIDTH-1:0]          mem_doutb
);

  localparam int unsigned IDXW = (G_NREQ > 1) ? $clog2(G_NREQ) : 1;

  state_t                  state;
  logic [IDXW-1:0]         last_idx;
  logic [IDXW-1:0]         cur_idx;
  logic [G_LENWIDTH-1:0]   cnt;
  logic [G_NREQ-1:0]       arb_req;
  logic [G_NREQ-1:0]       arb_gnt;
  logic [IDXW-1:0]         arb_idx;
  logic [G_NREQ-1:0]       cur_oh;
  logic [G_ADDRWIDTH-1:0]  sel_addr;
  logic [G_LENWIDTH-1:0]   sel_len;

  // Grants are only offered from IDLE and never while reset is held.
  assign arb_req = (state == IDLE && !rst) ? rd_req : '0;

  bm2p_rr_arb #(.G_NREQ(G_NREQ)) u_arb (
    .req  (arb_req),
    .last (last_idx),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign rd_gnt   = arb_gnt;
  assign rd_rdata = mem_doutb;
  assign cur_oh   = G_NREQ'(1) << cur_idx;

  // Capture mux for the winning requester's fields.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < G_NREQ; i++) begin
      if (arb_idx == IDXW'(i)) begin
        sel_addr = rd_addr[i*G_ADDRWIDTH +: G_ADDRWIDTH];
        sel_len  = rd_len[i*G_LENWIDTH +: G_LENWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_enb   <= 1'b0;
      mem_addrb <= '0;
      cnt       <= '0;
      last_idx  <= IDXW'(G_NREQ - 1);
      cur_idx   <= '0;
      rd_rvalid <= '0;
      rd_rlast  <= '0;
    end else begin
      // Response side trails the memory enable by the one-cycle read latency.
      rd_rvalid <= mem_enb ? cur_oh : '0;
      rd_rlast  <= (mem_enb && cnt == '0) ? cur_oh : '0;
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            state     <= BURST;
            mem_enb   <= 1'b1;
            mem_addrb <= sel_addr;
            cnt       <= sel_len;
            last_idx  <= arb_idx;
            cur_idx   <= arb_idx;
          end
        end
        BURST: begin
          if (cnt == '0) begin
            state   <= IDLE;
            mem_enb <= 1'b0;
          end else begin
            cnt       <= cnt - G_LENWIDTH'(1);
            mem_addrb <= G_ADDRWIDTH'(addr_wrap_inc(32'(mem_addrb), 32'(G_MEMDEPTH - 1)));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bm2p_rd_sched.sv
// Randomized bench for bm2p_rd_sched against a cycle-scheduled transaction model.
module tb_bm2p_rd_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned LW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned RING  = 1024;
  localparam int M_HOLD = 0, M_RR = 1, M_RND = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      rd_req;
  logic [NREQ*AW-1:0]   rd_addr;
  logic [NREQ*LW-1:0]   rd_len;
  logic [NREQ-1:0]      rd_gnt, rd_rvalid, rd_rlast;
  logic [DW-1:0]        rd_rdata;
  logic                 mem_enb;
  logic [AW-1:0]        mem_addrb;
  logic [DW-1:0]        mem_doutb;

  bm2p_rd_sched #(
    .G_MEMWIDTH(DW), .G_MEMDEPTH(DEPTH), .G_NREQ(NREQ), .G_LENWIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rlast(rd_rlast), .rd_rdata(rd_rdata),
    .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
  );

  always #5 clk = ~clk;

  // Block memory read port, preloaded with word[a] = a.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
  always @(posedge clk) if (mem_enb) mem_doutb <= mem[mem_addrb];

  // Requester side.
  logic [NREQ-1:0] req_v = '0;
  int unsigned     a_q [NREQ];
  int unsigned     l_q [NREQ];
  assign rd_req = req_v;
  always_comb begin
    rd_addr = '0;
    rd_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd_addr[i*AW +: AW] = AW'(a_q[i]);
      rd_len[i*LW +: LW]  = LW'(l_q[i]);
    end
  end

  // Model: expected port activity per cycle, filled in at grant time.
  bit              m_enb  [RING];
  int unsigned     m_addr [RING];
  bit [NREQ-1:0]   m_rv   [RING];
  bit [NREQ-1:0]   m_rl   [RING];
  int unsigned     m_data [RING];
  int              free_at = 0;
  int unsigned     m_last  = NREQ - 1;
  logic            rst_d   = 1'b1;

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic new_req(input int i);
    req_v[i] = 1'b1;
    a_q[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH-6, DEPTH-1) : $urandom_range(0, DEPTH-1);
    l_q[i] = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
  endtask

  task automatic set_req(input int i, input int unsigned a, input int unsigned l);
    req_v[i] = 1'b1;
    a_q[i]   = a;
    l_q[i]   = l;
  endtask

  task automatic step(input int mode);
    bit [NREQ-1:0] g;
    int unsigned   pick, s;
    @(negedge clk);
    s    = cyc % RING;
    g    = '0;
    pick = 0;
    if (!rst && cyc >= free_at && req_v != '0) begin
      for (int unsigned i = 1; i <= NREQ; i++) begin
        pick = (m_last + i) % NREQ;
        if (req_v[pick]) break;
      end
      g[pick] = 1'b1;
      for (int unsigned j = 0; j <= l_q[pick]; j++) begin
        int unsigned e = (cyc + 1 + j) % RING;
        int unsigned r = (cyc + 2 + j) % RING;
        int unsigned a = (a_q[pick] + j) % DEPTH;
        m_enb[e]  = 1'b1;
        m_addr[e] = a;
        m_rv[r]   = g;
        m_data[r] = a;
        m_rl[r]   = (j == l_q[pick]) ? g : '0;
      end
      free_at = cyc + 2 + int'(l_q[pick]);
      m_last  = pick;
    end
    if (cyc > 0) begin
      chk("gnt", 64'(rd_gnt), 64'(g));
      chk("enb", 64'(mem_enb), 64'(m_enb[s]));
      if (m_enb[s]) chk("addr", 64'(mem_addrb), 64'(m_addr[s]));
      chk("rvalid", 64'(rd_rvalid), 64'(m_rv[s]));
      chk("rlast", 64'(rd_rlast), 64'(m_rl[s]));
      if (m_rv[s] != '0) chk("rdata", 64'(rd_rdata), 64'(m_data[s]));
      if (rst_d) chk("rst_addr", 64'(mem_addrb), 64'(0));
    end
    m_enb[s] = 1'b0;
    m_rv[s]  = '0;
    m_rl[s]  = '0;
    if (rst) begin
      for (int k = 0; k < RING; k++) begin
        m_enb[k] = 1'b0;
        m_rv[k]  = '0;
        m_rl[k]  = '0;
      end
      m_last  = NREQ - 1;
      free_at = cyc + 1;
    end
    rst_d = rst;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        if (mode == M_RR) l_q[i] = 0;
        else if (mode == M_RND && $urandom_range(0, 1) == 1) new_req(i);
        else req_v[i] = 1'b0;
      end else if (mode == M_RND && !req_v[i] && $urandom_range(0, 9) < 3) begin
        new_req(i);
      end
    end
    if (mode == M_RND) rst = ($urandom_range(0, 199) == 0);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step(M_HOLD);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a_q[i] = 0;
      l_q[i] = 0;
    end
    do_reset(3);
    // Single beat, then a wrapping burst.
    set_req(0, 5, 0);
    repeat (6) step(M_HOLD);
    set_req(1, DEPTH-2, 3);
    repeat (10) step(M_HOLD);
    // Round-robin rotation with every requester asking for single beats.
    do_reset(2);
    for (int i = 0; i < NREQ; i++) set_req(i, 16*i, 0);
    repeat (12) step(M_RR);
    req_v = '0;
    repeat (4) step(M_HOLD);
    // Contention: requester 2 arrives while requester 0 bursts.
    set_req(0, 100, 7);
    step(M_HOLD);
    set_req(2, 200, 2);
    repeat (16) step(M_HOLD);
    // Reset on the third beat of a long burst, then 0 and 3 contend.
    set_req(0, 10, 7);
    repeat (3) step(M_HOLD);
    rst = 1'b1;
    step(M_HOLD);
    rst = 1'b0;
    set_req(0, 40, 1);
    set_req(3, 60, 1);
    repeat (12) step(M_HOLD);
    // Maximum length burst crossing the top of memory.
    set_req(1, 900, 255);
    repeat (262) step(M_HOLD);
    // Random traffic with occasional resets.
    repeat (5000) step(M_RND);
    rst   = 1'b0;
    req_v = '0;
    repeat (300) step(M_HOLD);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
